// File: rtl/uart_key_decoder.sv
// Shared 8N1 UART receiver driving a bank of per-key comparators.
// Each key output either toggles on its code or holds high for HOLD_CYCLES.

module uart_key_lane #(
    parameter int MODE        = 0,
    parameter int HOLD_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic hit,
    output logic q
);
    if (MODE == 0) begin : g_toggle
        always_ff @(posedge clk) begin
            if (rst)      q <= 1'b0;
            else if (hit) q <= ~q;
        end
    end else begin : g_hold
        localparam int HW = $clog2(HOLD_CYCLES + 1);
        logic [HW-1:0] hcnt;

        // A hit always wins, so a retrigger on the expiry cycle keeps q high.
        always_ff @(posedge clk) begin
            if (rst) begin
                hcnt <= '0;
                q    <= 1'b0;
            end else if (hit) begin
                hcnt <= HW'(HOLD_CYCLES);
                q    <= 1'b1;
            end else if (hcnt != '0) begin
                hcnt <= hcnt - 1'b1;
                if (hcnt == HW'(1)) q <= 1'b0;
            end
        end
    end
endmodule

module uart_key_decoder #(
    parameter int                  CLKS_PER_BIT = 868,
    parameter int                  N_KEYS       = 8,
    parameter logic [8*N_KEYS-1:0] KEY_CODES    = {8'h61, 8'h73, 8'h64, 8'h66,
                                                   8'h7a, 8'h78, 8'h63, 8'h76},
    parameter int                  MODE         = 0,
    parameter int                  HOLD_CYCLES  = 10_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_in,
    output logic [N_KEYS-1:0] out,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    output logic              frame_err
);
    localparam int            CW     = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_C = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic [1:0]    sync;
    logic          rxs;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [7:0]    shreg, shreg_nxt, data_nxt;
    logic          valid_nxt, ferr_nxt;

    assign rxs = sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync      <= 2'b11;
            state     <= WAIT_HIGH;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync      <= {sync[0], uart_in};
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            shreg     <= shreg_nxt;
            rx_data   <= data_nxt;
            rx_valid  <= valid_nxt;
            frame_err <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        data_nxt  = rx_data;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
        case (state)
            WAIT_HIGH: begin
                cnt_nxt = '0;
                if (rxs) state_nxt = IDLE;
            end
            IDLE: begin
                cnt_nxt = '0;
                if (!rxs) state_nxt = START;
            end
            START: if (cnt == HALF_C) begin
                cnt_nxt   = '0;
                idx_nxt   = '0;
                state_nxt = rxs ? IDLE : DATA;
            end
            DATA: if (cnt == LAST_C) begin
                cnt_nxt   = '0;
                shreg_nxt = {rxs, shreg[7:1]};
                idx_nxt   = idx + 3'd1;
                if (idx == 3'd7) state_nxt = STOP;
            end
            STOP: if (cnt == LAST_C) begin
                cnt_nxt = '0;
                // A low stop bit means the line may still be mid-break; wait for idle.
                if (rxs) begin
                    data_nxt  = shreg;
                    valid_nxt = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    ferr_nxt  = 1'b1;
                    state_nxt = WAIT_HIGH;
                end
            end
            default: state_nxt = WAIT_HIGH;
        endcase
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_lane
        uart_key_lane #(.MODE(MODE), .HOLD_CYCLES(HOLD_CYCLES)) u_lane (
            .clk (clk),
            .rst (rst),
            .hit (rx_valid && (rx_data == KEY_CODES[8*i +: 8])),
            .q   (out[i])
        );
    end
endmodule

// File: tb/tb_uart_key_decoder.sv
// Directed bench: toggle-mode decoder (dut0) and hold-mode decoder (dut1).
module tb_uart_key_decoder;
    localparam int C = 16;

    logic       clk = 1'b0;
    logic       rst, u0, u1;
    logic [7:0] out0, out1, rx_data0, rx_data1;
    logic       rx_valid0, rx_valid1, frame_err0, frame_err1;

    int checks = 0, errors = 0;
    int v0 = 0, fe0 = 0, v1 = 0, fe1 = 0, run1 = 0, hi1 = 0;
    int vsnap, fesnap;
    bit ok;

    always #5 clk = ~clk;

    uart_key_decoder #(.CLKS_PER_BIT(C), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .uart_in(u0), .out(out0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .frame_err(frame_err0));

    uart_key_decoder #(.CLKS_PER_BIT(C), .MODE(1), .HOLD_CYCLES(1000)) dut1 (
        .clk(clk), .rst(rst), .uart_in(u1), .out(out1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .frame_err(frame_err1));

    // run1: cycles out1[6] has been high since the last rx_valid1.
    always @(negedge clk) begin
        if (rx_valid0)  v0++;
        if (frame_err0) fe0++;
        if (rx_valid1)  v1++;
        if (frame_err1) fe1++;
        if (rx_valid1)    run1 = 0;
        else if (out1[6]) run1++;
        if (out1[6]) hi1++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit which, input logic v, input int n);
        if (which) u1 = v; else u0 = v;
        repeat (n) @(negedge clk);
    endtask

    // rst_bit >= 0 pulses rst for one edge early in that data bit.
    task automatic send(input bit which, input logic [7:0] b, input logic stop, input int rst_bit);
        drive(which, 1'b0, C);
        for (int k = 0; k < 8; k++) begin
            if (k == rst_bit) begin
                drive(which, b[k], 1);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_out", out0, 8'h00);
                check("rst_rx_data", rx_data0, 8'h00);
                check("rst_strobes", {rx_valid0, frame_err0}, 2'b00);
                vsnap  = v0;
                fesnap = fe0;
                drive(which, b[k], C - 2);
            end else begin
                drive(which, b[k], C);
            end
        end
        drive(which, stop, C);
    endtask

    task automatic wait_drop(input int lim, output bit done);
        done = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (!out1[6]) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1; u0 = 1'b1; u1 = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_out", out0, 8'h00);
        check("reset_rx_data", rx_data0, 8'h00);
        check("reset_strobes", {rx_valid0, frame_err0}, 2'b00);
        check("reset_out_hold", out1, 8'h00);
        drive(0, 1'b1, 2 * C);

        // toggle on and off
        send(0, 8'h61, 1'b1, -1);
        check("t1_valid_cnt", v0, 1);
        check("t1_rx_data", rx_data0, 8'h61);
        check("t1_out_on", out0, 8'h80);
        send(0, 8'h61, 1'b1, -1);
        check("t1_out_off", out0, 8'h00);
        check("t1_valid_cnt2", v0, 2);

        // independent keys, then an unmatched byte
        send(0, 8'h76, 1'b1, -1);
        send(0, 8'h7a, 1'b1, -1);
        check("t2_out", out0, 8'h09);
        send(0, 8'h71, 1'b1, -1);
        check("t2_valid_cnt", v0, 5);
        check("t2_rx_data", rx_data0, 8'h71);
        check("t2_out_unchanged", out0, 8'h09);
        check("t2_no_ferr", fe0, 0);

        // hold, exact length
        hi1 = 0;
        send(1, 8'h73, 1'b1, -1);
        check("t3_out_high", out1, 8'h40);
        wait_drop(1500, ok);
        check("t3_drop_seen", ok, 1);
        @(negedge clk);
        check("t3_hold_len", run1, 1000);
        check("t3_total_len", hi1, 1000);

        // retrigger with about 500 cycles remaining
        hi1 = 0;
        send(1, 8'h73, 1'b1, -1);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (run1 >= 345) begin ok = 1'b1; break; end
        end
        check("t3_run_reached", ok, 1);
        send(1, 8'h73, 1'b1, -1);
        check("t3_still_high", out1[6], 1'b1);
        wait_drop(2000, ok);
        check("t3_drop2_seen", ok, 1);
        @(negedge clk);
        check("t3_retrig_len", run1, 1000);
        check("t3_retrig_extended", hi1 > 1000, 1);
        check("t3_valid_cnt", v1, 3);
        check("t3_no_ferr", fe1, 0);

        // framing error with line held low
        send(0, 8'h55, 1'b0, -1);
        drive(0, 1'b0, 20 * C);
        check("t4_ferr_cnt", fe0, 1);
        check("t4_no_valid", v0, 5);
        check("t4_rx_data_kept", rx_data0, 8'h71);
        check("t4_out_kept", out0, 8'h09);
        drive(0, 1'b1, 2 * C);
        send(0, 8'h64, 1'b1, -1);
        check("t4_out_after", out0, 8'h29);

        // glitch rejection
        drive(0, 1'b0, C / 4);
        drive(0, 1'b1, 3 * C);
        check("t5_no_valid", v0, 6);
        check("t5_no_ferr", fe0, 1);
        send(0, 8'h63, 1'b1, -1);
        check("t5_idle_ok", out0, 8'h2b);

        // reset during data bit 4 of a 0x66 frame
        send(0, 8'h66, 1'b1, 4);
        check("t6_no_valid", v0, vsnap);
        check("t6_no_ferr", fe0, fesnap);
        check("t6_out_zero", out0, 8'h00);
        drive(0, 1'b1, 12 * C);
        send(0, 8'h66, 1'b1, -1);
        check("t6_rx_data", rx_data0, 8'h66);
        check("t6_out", out0, 8'h10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_key_decoder.md
# uart_key_decoder

Parametrised UART keyboard decoder: a single shared 8N1 UART receiver feeds a bank of N_KEYS comparators, each mapping one ASCII code to one output bit. It replaces the one-receiver-per-key arrangement on the board-level input path, and adds a toggle/hold mode, a per-key hold timeout, a received-byte strobe and framing-error detection.

## Interface

- CLKS_PER_BIT, default 868: clock cycles per UART bit (100 MHz / 115200); must be >= 4.
- N_KEYS, default 8: number of key outputs.
- KEY_CODES, default {8'h61,8'h73,8'h64,8'h66,8'h7a,8'h78,8'h63,8'h76}: 8*N_KEYS bits. The code for out[i] is KEY_CODES[8*i +: 8], so the default maps out[7..0] = 'a','s','d','f','z','x','c','v'.
- MODE, default 0: 0 = toggle, 1 = hold.
- HOLD_CYCLES, default 10_000_000: hold duration in MODE 1; must be >= 1.

Ports:

- clk  input  1  system clock; one clock domain only.
- rst  input  1  synchronous, active-high reset.
- uart_in  input  1  asynchronous serial line; idles high.
- out  output  N_KEYS  key states.
- rx_data  output  8  last correctly framed byte.
- rx_valid  output  1  one-cycle strobe when rx_data updates.
- frame_err  output  1  one-cycle strobe on a bad stop bit.

## Operation

- **Synchroniser:** uart_in passes through a 2-FF synchroniser (reset value 1). Everything below uses the synchronised line, rxs.
- **Receiver FSM states:** WAIT_HIGH, IDLE, START, DATA, STOP. One bit-period counter and a 3-bit bit index.
- **WAIT_HIGH:** go to IDLE when rxs = 1.
- **IDLE:** go to START when rxs = 0, and clear the counter.
- **START:** at count CLKS_PER_BIT/2 − 1 (integer division), sample rxs.
  - rxs = 0: go to DATA.
  - rxs = 1: treat as a glitch and return to IDLE.
- **DATA:** sample every CLKS_PER_BIT cycles, LSB first, into a shift register. After bit 7, go to STOP.
- **STOP:** sample after a further CLKS_PER_BIT cycles.
  - rxs = 1: load rx_data, pulse rx_valid, go to IDLE.
  - rxs = 0: pulse frame_err, leave rx_data unchanged, go to WAIT_HIGH.
- **Matching:** on rx_valid, match[i] = (rx_data == KEY_CODES[8*i +: 8]) for every i.
  - Duplicate codes are allowed; every matching bit acts.
  - A byte that matches no key causes no action, but rx_valid still pulses.
- **MODE 0 (toggle):** out[i] inverts on each match.
- **MODE 1 (hold):**
  - A match sets out[i] = 1 and loads counter[i] = HOLD_CYCLES. A re-match retriggers (reloads) the counter.
  - Otherwise a nonzero counter[i] decrements each cycle; out[i] clears in the cycle the counter reaches 0.
  - Counter width is clog2(HOLD_CYCLES+1) bits; the counter never wraps below 0.
- **Reset (rst = 1 at a clk edge):**
  - out = 0, rx_data = 0, rx_valid = 0, frame_err = 0.
  - Hold counters = 0, synchroniser = 1, FSM = WAIT_HIGH.
  - Reset mid-frame abandons the frame with no strobe. Entering WAIT_HIGH stops mid-frame zeros being taken as a start bit.

## Timing

- **t0:** the first cycle in which rxs = 0 while in IDLE. t0 is 2 cycles after uart_in falls, relative to clk.
- **Sample points:**
  - Start bit: t0 + CLKS_PER_BIT/2.
  - Data bit k (k = 0..7): t0 + CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT.
  - Stop bit: t0 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT.
- **Strobes:** rx_valid or frame_err is high for exactly the one cycle after the stop sample. rx_data is valid from that same cycle.
- **Key outputs:** out updates on the clk edge ending the rx_valid cycle, i.e. 1 cycle after rx_valid.
- **Hold length:** in MODE 1, out[i] stays high for exactly HOLD_CYCLES cycles after the last match update.
- **Back-to-back frames:** a new start bit is accepted from the cycle after the STOP sample. This allows back-to-back frames at full baud with a 1-stop-bit gap.
- **Counter precedence:** a retrigger in the same cycle as expiry wins; out[i] stays 1.

## Test plan

1. **Toggle on and off:** MODE 0, defaults; send 0x61.
   - Expect one rx_valid with rx_data = 0x61, then out = 8'h80.
   - Send 0x61 again; expect out = 8'h00.
2. **Independent keys and unmatched byte:** MODE 0; send 0x76 then 0x7a.
   - Expect out = 8'h09.
   - Send 0x71; expect rx_valid with rx_data = 0x71 and out still 8'h09. Check frame_err never asserts.
3. **Hold and retrigger:** MODE 1, HOLD_CYCLES = 1000, CLKS_PER_BIT = 16.
   - Send 0x73; expect out[6] high for exactly 1000 cycles, then 0.
   - Resend 0x73 when 500 cycles remain; expect out[6] high until 1000 cycles after the second update.
4. **Framing error:** drive a frame with stop bit = 0 and hold the line low for 20 bit times.
   - Expect one frame_err pulse, no rx_valid, rx_data and out unchanged, and no spurious frame while the line is low.
   - Release the line and send 0x64; expect out[5] = 1.
5. **Glitch rejection:** pulse uart_in low for CLKS_PER_BIT/4 cycles.
   - Expect no rx_valid, no frame_err, and the FSM back in IDLE.
6. **Reset mid-frame:** assert rst for 1 cycle after data bit 3 of a 0x66 frame.
   - Expect all outputs 0 and no strobe for the rest of that frame.
   - The next 0x66 frame sets out[4] = 1.
